// File: rtl/vram_write_buffer.sv
// vram_write_buffer: posted-write FIFO between one requester and one memory bus port.
// Writes are acknowledged on enqueue and drained in order; reads pass through to the bus.
// Optional macro WRITE_BUFFER_LEVEL_EN adds the o_level port (current FIFO count).
//
// Front FSM
//   state      | meaning
//   F_IDLE     | waiting for a request; writes enqueue here when not full
//   F_RD_WAIT  | read accepted, waiting for the bus read to complete
//   F_HOLD     | completion cycle; i_request ignored so one request is not taken twice
//
// Bus FSM
//   state      | meaning
//   B_IDLE     | no bus op; also the mandatory gap cycle between bus ops
//   B_RAM      | head entry being read out of the entry RAM
//   B_WAIT     | bus op presented, waiting for i_bus_ready
module vram_write_buffer #(
  parameter int DEPTH      = 4096,
  parameter int STALL_READ = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  output logic                   o_empty,
  output logic                   o_full,
`ifdef WRITE_BUFFER_LEVEL_EN
  output logic [$clog2(DEPTH):0] o_level,
`endif
  input  logic                   i_request,
  input  logic                   i_rw,
  input  logic [31:0]            i_address,
  input  logic [31:0]            i_wdata,
  output logic [31:0]            o_rdata,
  output logic                   o_ready,
  output logic                   o_bus_request,
  output logic                   o_bus_rw,
  output logic [31:0]            o_bus_address,
  output logic [31:0]            o_bus_wdata,
  input  logic [31:0]            i_bus_rdata,
  input  logic                   i_bus_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {F_IDLE, F_RD_WAIT, F_HOLD} front_t;
  typedef enum logic [1:0] {B_IDLE, B_RAM, B_WAIT} bus_t;

  front_t front_q, front_d;
  bus_t   bus_q, bus_d;

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   ram_q;

  logic          push, pop;
  logic          ready_d;
  logic [31:0]   rdata_d;
  logic          rd_done, read_go, wr_in_flight;
  logic          breq_d, brw_d;
  logic [31:0]   baddr_d, bwdata_d;

  assign o_full       = (count == PW'(DEPTH));
  // The in-flight entry is popped only on completion, so count alone would do;
  // the explicit term keeps the meaning obvious.
  assign wr_in_flight = (bus_q == B_RAM) || ((bus_q == B_WAIT) && o_bus_rw);
  assign o_empty      = (count == '0) && !wr_in_flight;
`ifdef WRITE_BUFFER_LEVEL_EN
  assign o_level      = count;
`endif

  assign rd_done = (bus_q == B_WAIT) && !o_bus_rw && i_bus_ready;
  // With STALL_READ the read may only start once every posted write has drained.
  assign read_go = (front_q == F_RD_WAIT) && ((STALL_READ == 0) || (count == '0));

  // Front FSM next-state and completion outputs.
  always_comb begin
    front_d = front_q;
    push    = 1'b0;
    ready_d = 1'b0;
    rdata_d = o_rdata;
    case (front_q)
      F_IDLE: begin
        if (i_request) begin
          if (i_rw) begin
            if (!o_full) begin
              push    = 1'b1;
              ready_d = 1'b1;
              front_d = F_HOLD;
            end
          end else begin
            front_d = F_RD_WAIT;
          end
        end
      end
      F_RD_WAIT: begin
        if (rd_done) begin
          rdata_d = i_bus_rdata;
          ready_d = 1'b1;
          front_d = F_HOLD;
        end
      end
      F_HOLD:  front_d = F_IDLE;
      default: front_d = F_IDLE;
    endcase
  end

  // Bus FSM next-state and bus outputs; outputs only change when starting or ending an op.
  always_comb begin
    bus_d    = bus_q;
    breq_d   = o_bus_request;
    brw_d    = o_bus_rw;
    baddr_d  = o_bus_address;
    bwdata_d = o_bus_wdata;
    pop      = 1'b0;
    case (bus_q)
      B_IDLE: begin
        if (read_go) begin
          breq_d   = 1'b1;
          brw_d    = 1'b0;
          baddr_d  = i_address;
          bwdata_d = '0;
          bus_d    = B_WAIT;
        end else if (count != '0) begin
          bus_d = B_RAM;
        end
      end
      B_RAM: begin
        breq_d   = 1'b1;
        brw_d    = 1'b1;
        baddr_d  = ram_q[63:32];
        bwdata_d = ram_q[31:0];
        bus_d    = B_WAIT;
      end
      B_WAIT: begin
        if (i_bus_ready) begin
          breq_d = 1'b0;
          pop    = o_bus_rw;
          bus_d  = B_IDLE;
        end
      end
      default: bus_d = B_IDLE;
    endcase
  end

  // Entry RAM: one write port, one registered read port addressed by the head pointer.
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {i_address, i_wdata};
    ram_q <= mem[rd_ptr[AW-1:0]];
  end

  // State, pointers, count and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      front_q       <= F_IDLE;
      bus_q         <= B_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_ready       <= 1'b0;
      o_rdata       <= '0;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
    end else begin
      front_q       <= front_d;
      bus_q         <= bus_d;
      o_ready       <= ready_d;
      o_rdata       <= rdata_d;
      o_bus_request <= breq_d;
      o_bus_rw      <= brw_d;
      o_bus_address <= baddr_d;
      o_bus_wdata   <= bwdata_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_buffer.sv
// Testbench for vram_write_buffer: dut0 (DEPTH=16, reads bypass) and dut1 (DEPTH=4, reads stall).
module tb_vram_write_buffer;

  typedef struct packed {
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req, rw, empty, full, ready, breq, brw, brdy;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [31:0] baddr [2];
  logic [31:0] bwdata [2];
  logic [31:0] brdata [2];
`ifdef WRITE_BUFFER_LEVEL_EN
  logic [4:0]  lvl0;
  logic [2:0]  lvl1;
  logic [4:0]  lvl_peak = '0;
`endif

  int total = 0;
  int bad   = 0;

  int   delay [2];
  bit   hold [2];
  int   done_cnt [2];
  bit   busy [2];
  int   cnt [2];
  op_t  cur [2];
  op_t  log0 [$];
  op_t  log1 [$];
  logic [31:0] bmem0 [logic [31:0]];
  logic [31:0] bmem1 [logic [31:0]];
  logic [31:0] sw [logic [31:0]];
  int   dsnap;
  int   lat5;

  vram_write_buffer #(.DEPTH(16), .STALL_READ(0)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .o_empty(empty[0]), .o_full(full[0]),
`ifdef WRITE_BUFFER_LEVEL_EN
    .o_level(lvl0),
`endif
    .i_request(req[0]), .i_rw(rw[0]), .i_address(addr[0]), .i_wdata(wdata[0]),
    .o_rdata(rdata[0]), .o_ready(ready[0]), .o_bus_request(breq[0]), .o_bus_rw(brw[0]),
    .o_bus_address(baddr[0]), .o_bus_wdata(bwdata[0]), .i_bus_rdata(brdata[0]),
    .i_bus_ready(brdy[0])
  );

  vram_write_buffer #(.DEPTH(4), .STALL_READ(1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .o_empty(empty[1]), .o_full(full[1]),
`ifdef WRITE_BUFFER_LEVEL_EN
    .o_level(lvl1),
`endif
    .i_request(req[1]), .i_rw(rw[1]), .i_address(addr[1]), .i_wdata(wdata[1]),
    .o_rdata(rdata[1]), .o_ready(ready[1]), .o_bus_request(breq[1]), .o_bus_rw(brw[1]),
    .o_bus_address(baddr[1]), .o_bus_wdata(bwdata[1]), .i_bus_rdata(brdata[1]),
    .i_bus_ready(brdy[1])
  );

`ifdef WRITE_BUFFER_LEVEL_EN
  always @(negedge clk) if (lvl0 > lvl_peak) lvl_peak <= lvl0;
`endif

  function automatic op_t mk_op(logic w, logic [31:0] a, logic [31:0] d, logic e);
    op_t o;
    o.rw = w; o.a = a; o.d = d; o.e = e;
    return o;
  endfunction

  // Bus memory: unwritten locations read back as a fixed function of the address.
  function automatic logic [31:0] bmem_get(int k, logic [31:0] a);
    if (k == 0) return bmem0.exists(a) ? bmem0[a] : (a ^ 32'h5A5A_5A5A);
    return bmem1.exists(a) ? bmem1[a] : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus responder for both ports: logs each op, answers after delay[k] cycles unless held.
  initial begin
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; cnt[k] = 0; brdy[k] = 1'b0; brdata[k] = '0; done_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          brdy[k] = 1'b0; busy[k] = 1'b0;
        end else if (brdy[k]) begin
          brdy[k] = 1'b0;
        end else begin
          if (!busy[k] && breq[k]) begin
            busy[k] = 1'b1; cnt[k] = 0;
            cur[k] = mk_op(brw[k], baddr[k], bwdata[k], empty[k]);
            if (k == 0) log0.push_back(cur[k]); else log1.push_back(cur[k]);
          end
          if (busy[k] && !hold[k]) begin
            if (cnt[k] >= delay[k]) begin
              if (cur[k].rw) begin
                if (k == 0) bmem0[cur[k].a] = cur[k].d; else bmem1[cur[k].a] = cur[k].d;
              end else begin
                brdata[k] = bmem_get(k, cur[k].a);
              end
              brdy[k] = 1'b1; busy[k] = 1'b0; done_cnt[k]++;
            end else begin
              cnt[k]++;
            end
          end
        end
      end
    end
  end

  task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    req[k] = 1'b1; rw[k] = w; addr[k] = a; wdata[k] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready[k] && lat < 300);
    check("xact_ready", ready[k], 1'b1);
    rd = rdata[k];
    req[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (!(empty[k] && !breq[k]) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drain", (n < 600), 1'b1);
  endtask

  task automatic check_log(input int k, input op_t exp[$], input bit writes_only);
    op_t got [$];
    op_t src [$];
    if (k == 0) src = log0; else src = log1;
    foreach (src[i]) if (!writes_only || src[i].rw) got.push_back(src[i]);
    check("log_len", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check("log_rw", got[i].rw, exp[i].rw);
      check("log_addr", got[i].a, exp[i].a);
      if (exp[i].rw) check("log_data", got[i].d, exp[i].d);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rd, a, d, e;
    int lat;
    op_t exp [$];

    req = '0; rw = '0;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; wdata[k] = '0; delay[k] = 1; hold[k] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Reset state of both instances
    for (int k = 0; k < 2; k++) begin
      check("rst_empty", empty[k], 1'b1);
      check("rst_full", full[k], 1'b0);
      check("rst_ready", ready[k], 1'b0);
      check("rst_breq", breq[k], 1'b0);
      check("rst_brw", brw[k], 1'b0);
      check("rst_baddr", baddr[k], 32'h0);
      check("rst_bwdata", bwdata[k], 32'h0);
      check("rst_rdata", rdata[k], 32'h0);
    end
`ifdef WRITE_BUFFER_LEVEL_EN
    check("rst_level", lvl0, 5'd0);
`endif
    rst_n = 1'b1;

    // Single write
    exp = {};
    xact(0, 1'b1, 32'h100, 32'hDEAD_BEEF, rd, lat);
    check("wr1_latency", lat, 1);
    check("wr1_not_empty", empty[0], 1'b0);
    wait_idle(0);
    exp.push_back(mk_op(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0));
    check_log(0, exp, 1'b0);
    check("wr1_empty_after", empty[0], 1'b1);

    // Eight writes, slow bus
    log0.delete(); exp = {};
    delay[0] = 5;
    for (int i = 0; i < 8; i++) begin
      a = 32'(i * 4);
      xact(0, 1'b1, a, a ^ 32'hA5A5_A5A5, rd, lat);
      check("wr8_latency", lat, 1);
      exp.push_back(mk_op(1'b1, a, a ^ 32'hA5A5_A5A5, 1'b0));
    end
    wait_idle(0);
    check_log(0, exp, 1'b0);
`ifdef WRITE_BUFFER_LEVEL_EN
    check("level_peak_ge7", (lvl_peak >= 5'd7), 1'b1);
`endif

    // Full boundary on the 4-deep instance
    log1.delete(); exp = {};
    delay[1] = 0; hold[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fill_not_full", full[1], 1'b0);
      xact(1, 1'b1, 32'h1000 + 32'(i * 4), 32'h100 + 32'(i), rd, lat);
      check("fill_latency", lat, 1);
      exp.push_back(mk_op(1'b1, 32'h1000 + 32'(i * 4), 32'h100 + 32'(i), 1'b0));
    end
    check("full_after_4", full[1], 1'b1);
    dsnap = 0; lat5 = 0;
    fork
      begin
        xact(1, 1'b1, 32'h1010, 32'h104, rd, lat5);
        dsnap = done_cnt[1];
      end
      begin
        d = 32'(done_cnt[1]);
        repeat (10) @(negedge clk);
        check("full_held", full[1], 1'b1);
        hold[1] = 1'b0;
      end
    join
    check("wr5_waited", (lat5 > 9), 1'b1);
    check("wr5_after_bus_ready", (dsnap > int'(d)), 1'b1);
    exp.push_back(mk_op(1'b1, 32'h1010, 32'h104, 1'b0));
    wait_idle(1);
    check_log(1, exp, 1'b0);

    // Read bypasses queued writes (dut0) / waits for them (dut1)
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin log0.delete(); bmem0[32'h40] = 32'h1234_5678; end
      else begin log1.delete(); bmem1[32'h40] = 32'h1234_5678; end
      exp = {};
      delay[k] = 2; hold[k] = 1'b1;
      for (int i = 0; i < 3; i++) begin
        d = $urandom;
        xact(k, 1'b1, 32'h200 + 32'(i * 4), d, rd, lat);
        exp.push_back(mk_op(1'b1, 32'h200 + 32'(i * 4), d, 1'b0));
      end
      rd = '0;
      fork
        xact(k, 1'b0, 32'h40, 32'h0, rd, lat);
        begin
          repeat (6) @(negedge clk);
          hold[k] = 1'b0;
        end
      join
      check("read_data", rd, 32'h1234_5678);
      wait_idle(k);
      if (k == 0) exp.insert(1, mk_op(1'b0, 32'h40, 32'h0, 1'b0));
      else exp.push_back(mk_op(1'b0, 32'h40, 32'h0, 1'b0));
      check_log(k, exp, 1'b0);
      if (k == 0 && log0.size() == 4) check("read_issue_empty_bypass", log0[1].e, 1'b0);
      if (k == 1 && log1.size() == 4) check("read_issue_empty_stall", log1[3].e, 1'b1);
    end

    // Random mix on the stalling instance: reads see every earlier write, bus order = program order
    log1.delete(); bmem1.delete(); sw.delete(); exp = {};
    for (int i = 0; i < 60; i++) begin
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      delay[1] = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0) begin
        xact(1, 1'b1, a, d, rd, lat);
        sw[a] = d;
        exp.push_back(mk_op(1'b1, a, d, 1'b0));
      end else begin
        xact(1, 1'b0, a, 32'h0, rd, lat);
        e = sw.exists(a) ? sw[a] : (a ^ 32'h5A5A_5A5A);
        check("rand_read", rd, e);
        exp.push_back(mk_op(1'b0, a, 32'h0, 1'b0));
      end
    end
    wait_idle(1);
    check_log(1, exp, 1'b0);

    // Random mix on the bypassing instance: writes still drain in acceptance order
    log0.delete(); exp = {};
    for (int i = 0; i < 40; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      delay[0] = $urandom_range(0, 4);
      if ($urandom_range(0, 3) != 0) begin
        xact(0, 1'b1, a, d, rd, lat);
        check("rand_wr_latency", lat, 1);
        exp.push_back(mk_op(1'b1, a, d, 1'b0));
      end else begin
        xact(0, 1'b0, a, 32'h0, rd, lat);
      end
    end
    wait_idle(0);
    check_log(0, exp, 1'b1);

    // Reset while a bus write is outstanding with two entries queued
    hold[1] = 1'b1; delay[1] = 0;
    xact(1, 1'b1, 32'h300, 32'h1, rd, lat);
    xact(1, 1'b1, 32'h304, 32'h2, rd, lat);
    repeat (3) @(negedge clk);
    check("pre_rst_breq", breq[1], 1'b1);
    check("pre_rst_empty", empty[1], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_breq", breq[1], 1'b0);
    check("mid_rst_empty", empty[1], 1'b1);
    check("mid_rst_ready", ready[1], 1'b0);
    check("mid_rst_full", full[1], 1'b0);
`ifdef WRITE_BUFFER_LEVEL_EN
    check("mid_rst_level", lvl1, 3'd0);
`endif
    hold[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    log1.delete(); exp = {};
    xact(1, 1'b1, 32'h308, 32'hCAFE_F00D, rd, lat);
    check("post_rst_latency", lat, 1);
    wait_idle(1);
    exp.push_back(mk_op(1'b1, 32'h308, 32'hCAFE_F00D, 1'b0));
    check_log(1, exp, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
